// File: rtl/tts_pkg.sv
// Shared definitions for the truth-table sweeper.
package tts_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_APPLY  = 2'd1,
      S_FINISH = 2'd2
   } state_t;

   localparam int MAX_N_IN = 8;

endpackage

// File: rtl/sweep_counter.sv
// Vector index and per-vector hold counter for the sweeper.
module sweep_counter #(
   parameter int N_IN        = 4,
   parameter int HOLD_CYCLES = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clr,
   input  logic            adv,
   output logic [N_IN-1:0] idx,
   output logic            sample,
   output logic            last
);

   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

   logic [HW-1:0] hold;

   assign sample = (hold == HOLD_LAST);
   assign last   = sample && (&idx);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         idx  <= '0;
         hold <= '0;
      end else if (adv) begin
         if (sample) begin
            hold <= '0;
            if (!last)
               idx <= idx + 1'b1;
         end else begin
            hold <= hold + 1'b1;
         end
      end
   end

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus sweep of a 1-bit combinational DUT with
// truth-table capture and comparison against a golden table.
module truth_table_sweeper
   import tts_pkg::*;
#(
   parameter int N_IN        = 4,
   parameter int HOLD_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [(1<<N_IN)-1:0]   expected,
   output logic [N_IN-1:0]        vec_out,
   input  logic                   f_in,
   output logic                   busy,
   output logic                   done,
   output logic [(1<<N_IN)-1:0]   table_out,
   output logic [N_IN:0]          err_cnt,
   output logic [N_IN-1:0]        first_err_idx,
   output logic                   first_err_vld,
   output logic                   pass
);

   localparam int DEPTH = 1 << N_IN;

   state_t           state;
   logic [DEPTH-1:0] exp_r;
   logic [N_IN-1:0]  idx;
   logic             sample;
   logic             last;
   logic             accept;

   assign accept = (state == S_IDLE) && start;

   sweep_counter #(
      .N_IN        (N_IN),
      .HOLD_CYCLES (HOLD_CYCLES)
   ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr    (accept),
      .adv    (state == S_APPLY),
      .idx    (idx),
      .sample (sample),
      .last   (last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         exp_r         <= '0;
         vec_out       <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         table_out     <= '0;
         err_cnt       <= '0;
         first_err_idx <= '0;
         first_err_vld <= 1'b0;
         pass          <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  exp_r         <= expected;
                  table_out     <= '0;
                  err_cnt       <= '0;
                  first_err_idx <= '0;
                  first_err_vld <= 1'b0;
                  pass          <= 1'b0;
                  vec_out       <= '0;
                  busy          <= 1'b1;
                  state         <= S_APPLY;
               end
            end
            S_APPLY: begin
               if (sample) begin
                  table_out[idx] <= f_in;
                  if (f_in != exp_r[idx]) begin
                     err_cnt <= err_cnt + 1'b1;
                     if (!first_err_vld) begin
                        first_err_idx <= idx;
                        first_err_vld <= 1'b1;
                     end
                  end
                  // Last vector stays on vec_out; no wrap back to 0.
                  if (last)
                     state <= S_FINISH;
                  else
                     vec_out <= idx + 1'b1;
               end
            end
            S_FINISH: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               pass  <= (err_cnt == '0);
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
